// File: rtl/nwc_processor_core.sv
// rtl/nwc_processor_core.sv - negacyclic polynomial multiplier mod (x^N + 1, q) with P parallel MAC cores
module nwc_processor_core #(
    parameter int MOD_INDEX      = 0,
    parameter int LOG_CORE_COUNT = 3,
    parameter int LOG_N          = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [59:0] data_in0,
    input  logic [59:0] data_in1,
    input  logic        write_enable,
    input  logic        start,
    output logic [59:0] data_out,
    output logic        output_active,
    output logic        ready
);
    localparam int N  = 1 << LOG_N;
    localparam int W  = N / 2;
    localparam int P  = 1 << LOG_CORE_COUNT;
    localparam int GW = LOG_N - LOG_CORE_COUNT;
    localparam int AW = LOG_N - 1;

    localparam logic [29:0] Q = (MOD_INDEX == 0) ? 30'd1073479681 :
                                (MOD_INDEX == 1) ? 30'd1072496641 :
                                (MOD_INDEX == 2) ? 30'd1071513601 : 30'd1070727169;
    // Barrett constant floor(2^60 / q); q has 30 significant bits
    localparam logic [30:0] MU = 31'(64'h1000_0000_0000_0000 / 64'(Q));

    typedef enum logic [2:0] {IDLE, PRELOAD, MAC, DRAIN, OUTPUT} state_t;
    state_t state, state_next;

    logic [59:0]      mem_a [W];
    logic [59:0]      mem_b [W];
    logic [29:0]      res   [N];

    logic [AW-1:0]    wa;
    logic [AW-1:0]    ocnt;
    logic [LOG_N-1:0] i_cnt;
    logic [GW-1:0]    g;
    logic             dcnt;

    logic [29:0]      win  [P];
    logic [P-1:0]     sgn;
    logic [29:0]      acc  [P];
    logic [59:0]      prod [P];
    logic [P-1:0]     psgn;
    logic             pvalid;

    logic [LOG_N-1:0] gbase;
    logic [LOG_N-1:0] feed_idx;
    logic [29:0]      feed_val;
    logic             feed_neg;
    logic [29:0]      a_cur;
    logic [LOG_N-1:0] pre_idx [P];
    logic [29:0]      pre_w   [P];

    function automatic logic [29:0] pick(input logic [59:0] word, input logic hi);
        return hi ? word[59:30] : word[29:0];
    endfunction

    // Barrett reduction of x < q^2: estimate is at most 2 low, so two corrections suffice
    function automatic logic [29:0] mod_reduce(input logic [59:0] x);
        logic [30:0] qhat;
        logic [31:0] r;
        qhat = 31'((62'(x[59:29]) * 62'(MU)) >> 31);
        r    = x[31:0] - 32'(qhat) * 32'(Q);
        if (r >= 32'(Q)) r = r - 32'(Q);
        if (r >= 32'(Q)) r = r - 32'(Q);
        return 30'(r);
    endfunction

    function automatic logic [29:0] mod_add(input logic [29:0] a, input logic [29:0] b);
        logic [30:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, Q}) ? 30'(s - {1'b0, Q}) : 30'(s);
    endfunction

    function automatic logic [29:0] mod_sub(input logic [29:0] a, input logic [29:0] b);
        return (a >= b) ? (a - b) : 30'({1'b0, a} + {1'b0, Q} - {1'b0, b});
    endfunction

    assign gbase    = LOG_N'(g) << LOG_CORE_COUNT;
    assign a_cur    = pick(mem_a[i_cnt[LOG_N-1:1]], i_cnt[0]);
    // coefficient entering the window after step i is b(gP-i-1), negated when that index wrapped
    assign feed_idx = gbase - i_cnt - LOG_N'(1);
    assign feed_val = pick(mem_b[feed_idx[LOG_N-1:1]], feed_idx[0]);
    assign feed_neg = (i_cnt >= gbase);

    // window contents for the start of a group: b(gP+p)
    always_comb begin
        for (int p = 0; p < P; p++) begin
            pre_idx[p] = gbase + LOG_N'(p);
            pre_w[p]   = pick(mem_b[pre_idx[p][LOG_N-1:1]], pre_idx[p][0]);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PRELOAD;
            PRELOAD: state_next = MAC;
            MAC:     if (i_cnt == '1) state_next = DRAIN;
            DRAIN:   if (dcnt) state_next = (g == '1) ? OUTPUT : PRELOAD;
            OUTPUT:  if (ocnt == '1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // counters, shift window, multiplier pipeline and accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa     <= '0;
            ocnt   <= '0;
            i_cnt  <= '0;
            g      <= '0;
            dcnt   <= 1'b0;
            sgn    <= '0;
            psgn   <= '0;
            pvalid <= 1'b0;
            for (int p = 0; p < P; p++) begin
                win[p]  <= '0;
                acc[p]  <= '0;
                prod[p] <= '0;
            end
        end else begin
            if (!write_enable)              wa <= '0;
            else if (state == IDLE)         wa <= wa + 1'b1;
            if (pvalid) begin
                for (int p = 0; p < P; p++) begin
                    acc[p] <= psgn[p] ? mod_sub(acc[p], mod_reduce(prod[p]))
                                      : mod_add(acc[p], mod_reduce(prod[p]));
                end
            end
            case (state)
                IDLE: begin
                    g    <= '0;
                    ocnt <= '0;
                end
                PRELOAD: begin
                    for (int p = 0; p < P; p++) begin
                        win[p] <= pre_w[p];
                        acc[p] <= '0;
                    end
                    sgn   <= '0;
                    i_cnt <= '0;
                end
                MAC: begin
                    for (int p = 0; p < P; p++) prod[p] <= 60'(a_cur) * 60'(win[p]);
                    psgn   <= sgn;
                    pvalid <= 1'b1;
                    for (int p = P - 1; p > 0; p--) win[p] <= win[p-1];
                    win[0] <= feed_val;
                    sgn    <= P'({sgn, feed_neg});
                    i_cnt  <= i_cnt + 1'b1;
                end
                DRAIN: begin
                    pvalid <= 1'b0;
                    dcnt   <= ~dcnt;
                    if (dcnt) g <= g + 1'b1;
                end
                OUTPUT: ocnt <= ocnt + 1'b1;
                default: ;
            endcase
        end
    end

    // operand memories: written only while idle, kept across computations
    always_ff @(posedge clk) begin
        if (state == IDLE && write_enable) begin
            mem_a[wa] <= data_in0;
            mem_b[wa] <= data_in1;
        end
    end

    // result memory: second drain cycle stores the finished group
    always_ff @(posedge clk) begin
        if (state == DRAIN && dcnt) begin
            for (int p = 0; p < P; p++) res[gbase + LOG_N'(p)] <= acc[p];
        end
    end

    assign ready         = (state == IDLE);
    assign output_active = (state == OUTPUT);
    assign data_out      = output_active ? {res[{ocnt, 1'b1}], res[{ocnt, 1'b0}]} : '0;

endmodule

// File: tb/tb_nwc_processor_core.sv
// tb/tb_nwc_processor_core.sv - self-checking bench for nwc_processor_core against a negacyclic convolution model
`timescale 1ns/1ps
module tb_nwc_processor_core;
    localparam int LOG_N = 6;
    localparam int N     = 64;
    localparam int W     = 32;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [59:0] din0, din1;
    logic        we;
    logic [1:0]  start_v;
    logic [59:0] dout [2];
    logic [1:0]  oa, rdy;

    always #5 clk = ~clk;

    nwc_processor_core #(.MOD_INDEX(0), .LOG_CORE_COUNT(3), .LOG_N(LOG_N)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in0(din0), .data_in1(din1), .write_enable(we),
        .start(start_v[0]), .data_out(dout[0]), .output_active(oa[0]), .ready(rdy[0]));

    nwc_processor_core #(.MOD_INDEX(3), .LOG_CORE_COUNT(0), .LOG_N(LOG_N)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in0(din0), .data_in1(din1), .write_enable(we),
        .start(start_v[1]), .data_out(dout[1]), .output_active(oa[1]), .ready(rdy[1]));

    longint a_m [N];
    longint b_m [N];
    longint exp_c [2][N];
    int     tests = 0;
    int     fails = 0;
    int     out_idx [2];
    int     bursts  [2];
    logic [1:0] prev_oa = 2'b00;

    function automatic longint qv(input int d);
        return (d == 0) ? 64'd1073479681 : 64'd1070727169;
    endfunction

    function automatic longint rnd();
        return longint'($urandom % 32'd1070727169);
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // c(k) = sum_{i+j=k} a(i)b(j) - sum_{i+j=k+N} a(i)b(j)  (mod q)
    function automatic longint model_c(input int d, input int k);
        longint q, s, pr;
        int j;
        q = qv(d);
        s = 0;
        for (int i = 0; i < N; i++) begin
            j = k - i;
            if (j >= 0) begin
                pr = (a_m[i] * b_m[j]) % q;
                s  = (s + pr) % q;
            end else begin
                pr = (a_m[i] * b_m[j + N]) % q;
                s  = (s + q - pr) % q;
            end
        end
        return s;
    endfunction

    task automatic build_expected();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) exp_c[d][k] = model_c(d, k);
    endtask

    // every-cycle output checker
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (oa[d]) begin
                    if (out_idx[d] < W)
                        check($sformatf("dut%0d word%0d", d, out_idx[d]), longint'(dout[d]),
                              longint'({exp_c[d][2*out_idx[d]+1][29:0], exp_c[d][2*out_idx[d]][29:0]}));
                    else
                        check($sformatf("dut%0d burst overrun", d), longint'(out_idx[d]), longint'(W - 1));
                    check($sformatf("dut%0d ready during output", d), longint'(rdy[d]), 0);
                    out_idx[d]++;
                end else begin
                    check($sformatf("dut%0d data_out idle", d), longint'(dout[d]), 0);
                end
                if (prev_oa[d] && !oa[d]) begin
                    bursts[d]++;
                    check($sformatf("dut%0d ready after output", d), longint'(rdy[d]), 1);
                end
                prev_oa[d] = oa[d];
            end
        end
    end

    task automatic load(input bit extra, input bit with_start);
        int total, w;
        total = W + (extra ? 1 : 0);
        for (int k = 0; k < total; k++) begin
            if (k == W) begin
                a_m[0] = rnd(); a_m[1] = rnd(); b_m[0] = rnd(); b_m[1] = rnd();
            end
            w    = k % W;
            din0 = {a_m[2*w+1][29:0], a_m[2*w][29:0]};
            din1 = {b_m[2*w+1][29:0], b_m[2*w][29:0]};
            we   = 1'b1;
            start_v = (with_start && k == total - 1) ? 2'b11 : 2'b00;
            @(negedge clk);
        end
        we = 1'b0; start_v = 2'b00; din0 = '0; din1 = '0;
    endtask

    task automatic run(input bit started, input bit disturb);
        int cyc;
        bit p0, p1;
        build_expected();
        out_idx[0] = 0; out_idx[1] = 0; bursts[0] = 0; bursts[1] = 0;
        if (!started) begin
            start_v = 2'b11;
            @(negedge clk);
            start_v = 2'b00;
        end
        check("dut0 ready low after start", longint'(rdy[0]), 0);
        check("dut1 ready low after start", longint'(rdy[1]), 0);
        cyc = 0; p0 = 1'b0; p1 = 1'b0;
        while (!(rdy[0] && rdy[1]) && cyc < LIMIT) begin
            start_v = 2'b00;
            we = 1'b0;
            if (disturb) begin
                if (cyc == 10) start_v = 2'b11;
                if (cyc >= 20 && cyc < 24) begin
                    we = 1'b1; din0 = 60'h123_4567_89AB_CDEF; din1 = 60'h0FE_DCBA_9876_5432;
                end
                if (oa[0] && !p0) begin start_v[0] = 1'b1; p0 = 1'b1; end
                if (oa[1] && !p1) begin start_v[1] = 1'b1; p1 = 1'b1; end
            end
            @(negedge clk);
            cyc++;
        end
        start_v = 2'b00; we = 1'b0; din0 = '0; din1 = '0;
        check("run timeout", longint'(cyc < LIMIT), 1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d output word count", d), longint'(out_idx[d]), longint'(W));
            check($sformatf("dut%0d output bursts", d), longint'(bursts[d]), 1);
        end
    endtask

    initial begin
        we = 1'b0; start_v = 2'b00; din0 = '0; din1 = '0;
        out_idx[0] = 0; out_idx[1] = 0; bursts[0] = 0; bursts[1] = 0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset ready", d), longint'(rdy[d]), 1);
            check($sformatf("dut%0d reset output_active", d), longint'(oa[d]), 0);
            check($sformatf("dut%0d reset data_out", d), longint'(dout[d]), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // A = 1: result equals B
        for (int k = 0; k < N; k++) begin a_m[k] = 0; b_m[k] = rnd(); end
        a_m[0] = 1;
        load(1'b0, 1'b0);
        run(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) check($sformatf("model identity c%0d", k), exp_c[0][k], b_m[k]);

        // x * x^(N-1) = x^N = -1
        for (int k = 0; k < N; k++) begin a_m[k] = 0; b_m[k] = 0; end
        a_m[1] = 1; b_m[N-1] = 1;
        load(1'b0, 1'b0);
        run(1'b0, 1'b0);
        check("model wrap q0 c0", exp_c[0][0], 64'd1073479680);
        check("model wrap q3 c0", exp_c[1][0], 64'd1070727168);
        check("model wrap c5", exp_c[0][5], 0);

        // all ones, start in the same cycle as the last write
        for (int k = 0; k < N; k++) begin a_m[k] = 1; b_m[k] = 1; end
        load(1'b0, 1'b1);
        run(1'b1, 1'b0);
        check("model ones q0 c0", exp_c[0][0], 64'd1073479619);
        check("model ones q3 c0", exp_c[1][0], 64'd1070727107);
        check("model ones c63", exp_c[0][63], 64);

        // random with one extra write wrapping to word 0
        for (int k = 0; k < N; k++) begin a_m[k] = rnd(); b_m[k] = rnd(); end
        load(1'b1, 1'b0);
        run(1'b0, 1'b0);

        // random, with start pulses and write attempts while busy
        for (int k = 0; k < N; k++) begin a_m[k] = rnd(); b_m[k] = rnd(); end
        load(1'b0, 1'b0);
        run(1'b0, 1'b1);

        // reuse retained memories without reloading
        run(1'b0, 1'b0);

        // abort mid-MAC via reset, then recompute from retained memories
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d abort ready", d), longint'(rdy[d]), 1);
            check($sformatf("dut%0d abort output_active", d), longint'(oa[d]), 0);
            check($sformatf("dut%0d abort data_out", d), longint'(dout[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 1'b0);

        // largest coefficients reduced for both moduli
        for (int k = 0; k < N; k++) begin a_m[k] = 64'd1070727168; b_m[k] = 64'd1070727168 - k; end
        load(1'b0, 1'b0);
        run(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nwc_processor_core.md
NWC_PROCESSOR_CORE -- requirements
Module: nwc_processor

Interface
REQ-001 Parameters: MOD_INDEX, default 0, selects modulus q: 0 -> 1073479681, 1 -> 1072496641, 2 -> 1071513601, 3 -> 1070727169; other values are illegal.
REQ-002 Parameters: LOG_CORE_COUNT, default 3, sets parallel MAC cores P = 2^LOG_CORE_COUNT, legal range 0..4.
REQ-003 Parameters: LOG_N, default 12, sets polynomial length N = 2^LOG_N and word count W = N/2; LOG_N > LOG_CORE_COUNT.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 data_in0  in  60  polynomial A word: [29:0] = a(2k), [59:30] = a(2k+1).
REQ-008 data_in1  in  60  polynomial B word, same packing as data_in0.
REQ-009 write_enable  in  1  load strobe, one word per cycle while high.
REQ-010 start  in  1  single-cycle compute request.
REQ-011 data_out  out  60  result word: [29:0] = c(2k), [59:30] = c(2k+1).
REQ-012 output_active  out  1  high while data_out carries a valid result word.
REQ-013 ready  out  1  high when idle and able to accept load or start.

Function
REQ-014 The block SHALL compute C = A*B mod (x^N + 1, q): c(k) = sum over i+j=k of a(i)b(j) minus sum over i+j=k+N of a(i)b(j), each c(k) in [0, q-1].
REQ-015 Input coefficients SHALL be treated as reduced (< q); results for unreduced inputs are unspecified.
REQ-016 Load: when ready = 1, each write_enable-high cycle SHALL write data_in0 and data_in1 to word address wa of the A and B memories, then increment wa.
REQ-017 wa SHALL reset to 0 on any cycle write_enable is low; more than W consecutive writes SHALL wrap to address 0.
REQ-018 write_enable when ready = 0 SHALL be ignored and SHALL not alter memory.
REQ-019 FSM states: IDLE, PRELOAD, MAC, DRAIN, OUTPUT; ready = 1 only in IDLE.
REQ-020 start in IDLE SHALL move to PRELOAD, with ready low from the next cycle; start in any other state SHALL be ignored.
REQ-021 start with write_enable high in the same IDLE cycle SHALL perform the write and then start.
REQ-022 Outputs are computed in N/P groups, g = 0..N/P-1; core p accumulates c(gP+p).
REQ-023 PRELOAD SHALL fill a P-entry shift window with w[p] = b(gP+p) and sign = +.
REQ-024 MAC SHALL run for i = 0..N-1, reading one a(i) per cycle and broadcasting it to all cores; core p SHALL add a(i)*w[p] when sign is + and subtract it when sign is -.
REQ-025 After each MAC step the window SHALL shift: w[p] <= w[p-1], and w[0] <= b((gP-i-1) mod N) with sign - when gP-i-1 < 0.
REQ-026 DRAIN SHALL flush the multiplier pipeline and store the P results to the result memory.
REQ-027 After DRAIN, the FSM SHALL go to PRELOAD for the next group, or to OUTPUT after the last group.
REQ-028 Modular multiply-reduce SHALL produce exact values mod q; the method (e.g. Barrett) and pipeline depth are free.
REQ-029 Modular add and subtract SHALL be single conditional-correction operations on 30-bit values.
REQ-030 OUTPUT SHALL assert output_active for exactly W consecutive cycles, presenting word k = 0..W-1 in order, one word per cycle.
REQ-031 data_out SHALL be 0 whenever output_active = 0.
REQ-032 After the final output word the FSM SHALL return to IDLE, with ready = 1 on the cycle after output_active falls.
REQ-033 A and B memories SHALL retain their contents across computations; start without a new load SHALL reuse them.
REQ-034 Loading during OUTPUT is ignored.

Reset
REQ-035 While rst_n = 0: FSM = IDLE, ready = 1, output_active = 0, data_out = 0, all counters, accumulators and the shift window = 0.
REQ-036 Reset mid-computation SHALL abort the computation without producing output.
REQ-037 Memory contents after reset are undefined.

Verification
REQ-038 A = 1 (a0 = 1, others 0), B random reduced -> output words equal B exactly, output_active high W cycles.
REQ-039 a(1) = 1, b(N-1) = 1, others 0 -> c(0) = q-1, all other c(k) = 0.
REQ-040 All a(i) = b(i) = 1 -> c(k) = (2k+2-N) mod q, e.g. c(0) = q-4094 and c(4095) = 4096 for N = 4096.
REQ-041 Pulse start again during MAC and during OUTPUT -> no effect: single W-cycle output burst, ready stays 0 until done.
REQ-042 Drop rst_n during MAC -> ready = 1 and output_active = 0 immediately; a subsequent start with retained A and B -> correct result.
REQ-043 Random A and B, all MOD_INDEX values, LOG_CORE_COUNT in {0, 3}, LOG_N = 6 -> matches the software negacyclic reference.
